// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, controller states and op decode helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'b00,
        MDU_MULU = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_DIVU = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } mdu_state_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement negation; yields |x| on the operand side
// and restores the result sign on the output side.
module mdu_sign_adjust #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: unsigned shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         state, state_nxt;
    mdu_op_t            op_in, op_q;
    logic               accept, last_step, div_zero_in;
    logic               neg_src1_in, neg_src2_in;
    logic [WIDTH-1:0]   abs_src1, abs_src2;
    logic               neg_res_q, neg_rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   b_q, hi_q, lo_q;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_adj;
    logic [WIDTH-1:0]   quo_adj, rem_adj;

    always_comb begin
        op_in       = mdu_op_t'(op);
        neg_src1_in = op_is_signed(op_in) && src1[WIDTH-1];
        neg_src2_in = op_is_signed(op_in) && src2[WIDTH-1];
        div_zero_in = op_is_div(op_in) && (src2 == '0);
    end

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_src1 (
        .value  (src1),
        .negate (neg_src1_in),
        .result (abs_src1)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_abs_src2 (
        .value  (src2),
        .negate (neg_src2_in),
        .result (abs_src2)
    );

    // hi_q/lo_q hold {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
        div_fits  = !div_trial[WIDTH];
        if (op_is_div(op_q)) begin
            step_hi = div_fits ? div_trial[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            step_lo = {lo_q[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    mdu_sign_adjust #(.WIDTH(2*WIDTH)) u_prod_sign (
        .value  ({step_hi, step_lo}),
        .negate (neg_res_q),
        .result (prod_adj)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_quo_sign (
        .value  (step_lo),
        .negate (neg_res_q),
        .result (quo_adj)
    );

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_rem_sign (
        .value  (step_hi),
        .negate (neg_rem_q),
        .result (rem_adj)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == ST_IDLE) && !flush;
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_DONE);
        accept    = in_valid && in_ready;
        last_step = (state == ST_CALC) && (cnt_q == CNT_LAST);
        case (state)
            ST_IDLE: if (accept)    state_nxt = div_zero_in ? ST_DONE : ST_CALC;
            ST_CALC: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // The final step writes the sign-corrected result back into hi_q/lo_q
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= MDU_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            neg_res_q <= neg_src1_in ^ neg_src2_in;
            neg_rem_q <= neg_src1_in;
            b_q       <= abs_src2;
            cnt_q     <= '0;
            if (div_zero_in) begin
                lo_q <= '1;
                hi_q <= src1;
            end else begin
                lo_q <= abs_src1;
                hi_q <= '0;
            end
        end else if (state == ST_CALC) begin
            if (last_step) begin
                cnt_q <= '0;
                if (op_is_div(op_q)) begin
                    lo_q <= quo_adj;
                    hi_q <= rem_adj;
                end else begin
                    {hi_q, lo_q} <= prod_adj;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                hi_q  <= step_hi;
                lo_q  <= step_lo;
            end
        end
    end

    always_comb begin
        out_lo = out_valid ? lo_q : '0;
        out_hi = out_valid ? hi_q : '0;
    end

endmodule
